// File: rtl/conv_bin_seq_pkg.sv
// conv_pkg: shared types and helpers for the sequential binary convolution.
//   state_e    - frame sequencer states (IDLE/RUN/DONE)
//   width_of   - clog2 clamped to at least one bit (for index fields)
//   out_w      - output map side for a given image/kernel side
//   cnt_w      - raw popcount width for a KxK window
//   sat        - clamp a count to the largest value representable in bw bits
//   DEF_*      - derived widths for the default configuration (28/5/10)
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned out_w(input int unsigned img_w, input int unsigned k);
    return img_w - k + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned k);
    return $clog2(k * k + 1);
  endfunction

  function automatic int unsigned sat(input int unsigned cnt, input int unsigned bw);
    int unsigned max_v;
    max_v = (bw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bw) - 32'd1);
    return (cnt > max_v) ? max_v : cnt;
  endfunction

  localparam int unsigned DEF_OUT_W = out_w(28, 5);
  localparam int unsigned DEF_CNT_W = cnt_w(5);
  localparam int unsigned DEF_CH_W  = width_of(10);
  localparam int unsigned DEF_POS_W = width_of(DEF_OUT_W);

endpackage

// File: rtl/conv_bin_seq_popcnt.sv
// bin_win_popcnt: combinational window engine.
//   win_i  - K*K window bits taken from the image
//   ker_i  - K*K kernel bits (same bit ordering as win_i)
//   mode_i - 0: count mismatches (XOR), 1: count matches (XNOR)
//   cnt_o  - popcount saturated to BW bits
module bin_win_popcnt
  import conv_pkg::*;
#(
  parameter int K  = 5,
  parameter int BW = 8
) (
  input  logic [K*K-1:0] win_i,
  input  logic [K*K-1:0] ker_i,
  input  logic           mode_i,
  output logic [BW-1:0]  cnt_o
);

  localparam int CNT_W = cnt_w(K);

  logic [CNT_W-1:0] cnt;

  // XNOR is XOR with the mode bit folded in: a ^ b ^ 1.
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < K * K; i++) begin
      cnt = cnt + CNT_W'(win_i[i] ^ ker_i[i] ^ mode_i);
    end
    cnt_o = BW'(sat(32'(cnt), BW));
  end

endmodule

// File: rtl/conv_bin_seq.sv
// conv_bin_seq: time-multiplexed binary first-layer convolution.
// Latches one image, NCH kernels and the mode on i_start, then streams every
// output element (channel-major, row, column) over a valid/ready interface.
//   i_clk, i_rst_n        - clock, synchronous active-low reset
//   i_start, i_mode       - frame start (IDLE only) and XOR/XNOR select
//   i_image, i_kernels    - packed ascending image / kernel bits
//   o_valid, i_ready      - output handshake
//   o_data                - saturated popcount for (o_ch, o_row, o_col)
//   o_ch, o_row, o_col    - coordinates of the current beat
//   o_last                - final beat of the frame
//   o_busy, o_done        - frame in progress / one-cycle end-of-frame pulse
module conv_bin_seq
  import conv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int NCH   = 10,
  parameter int BW    = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_mode,
  input  logic [0:IMG_W*IMG_W-1]         i_image,
  input  logic [0:NCH*K*K-1]             i_kernels,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [BW-1:0]                  o_data,
  output logic [width_of(NCH)-1:0]       o_ch,
  output logic [width_of(IMG_W-K+1)-1:0] o_row,
  output logic [width_of(IMG_W-K+1)-1:0] o_col,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int OUT_W  = IMG_W - K + 1;
  localparam int CH_W   = width_of(NCH);
  localparam int POS_W  = width_of(OUT_W);
  localparam int NPIX   = IMG_W * IMG_W;
  localparam int NKB    = NCH * K * K;
  localparam int PIX_IW = width_of(NPIX);
  localparam int KER_IW = width_of(NKB);

  if (K > IMG_W || NCH < 1) begin : g_param_check
    $error("conv_bin_seq: requires K <= IMG_W and NCH >= 1");
  end

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             more_q, more_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [POS_W-1:0] row_q, row_d;
  logic [POS_W-1:0] col_q, col_d;

  logic             valid_q, valid_d;
  logic [BW-1:0]    data_q, data_d;
  logic [CH_W-1:0]  och_q, och_d;
  logic [POS_W-1:0] orow_q, orow_d;
  logic [POS_W-1:0] ocol_q, ocol_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic [0:NPIX-1]  img_q;
  logic [0:NKB-1]   ker_q;

  logic [K*K-1:0]    win;
  logic [K*K-1:0]    ker_win;
  logic [PIX_IW-1:0] pix_idx;
  logic [KER_IW-1:0] ker_idx;
  logic [BW-1:0]     pop_cnt;

  logic accept;
  logic at_final;
  logic col_end;
  logic row_end;

  assign accept   = (state_q == IDLE) && i_start;
  assign col_end  = (col_q == POS_W'(OUT_W - 1));
  assign row_end  = (row_q == POS_W'(OUT_W - 1));
  assign at_final = (ch_q == CH_W'(NCH - 1)) && row_end && col_end;

  // Frame operands carry no reset: they are only observed after a start.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      img_q <= i_image;
      ker_q <= i_kernels;
    end
  end

  // Window mux for the current (ch,row,col) counters.
  always_comb begin
    win     = '0;
    ker_win = '0;
    pix_idx = '0;
    ker_idx = '0;
    for (int unsigned kr = 0; kr < K; kr++) begin
      for (int unsigned kc = 0; kc < K; kc++) begin
        pix_idx = PIX_IW'((32'(row_q) + kr) * IMG_W + 32'(col_q) + kc);
        ker_idx = KER_IW'(32'(ch_q) * K * K + kr * K + kc);
        win[kr*K+kc]     = img_q[pix_idx];
        ker_win[kr*K+kc] = ker_q[ker_idx];
      end
    end
  end

  bin_win_popcnt #(
    .K (K),
    .BW(BW)
  ) u_popcnt (
    .win_i (win),
    .ker_i (ker_win),
    .mode_i(mode_q),
    .cnt_o (pop_cnt)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    more_d  = more_q;
    ch_d    = ch_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    data_d  = data_q;
    och_d   = och_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    last_d  = last_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          mode_d  = i_mode;
          more_d  = 1'b1;
          ch_d    = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (valid_q && i_ready && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if ((!valid_q || i_ready) && more_q) begin
          valid_d = 1'b1;
          data_d  = pop_cnt;
          och_d   = ch_q;
          orow_d  = row_q;
          ocol_d  = col_q;
          last_d  = at_final;
          more_d  = !at_final;
          if (col_end) begin
            col_d = '0;
            if (row_end) begin
              row_d = '0;
              ch_d  = ch_q + CH_W'(1);
            end else begin
              row_d = row_q + POS_W'(1);
            end
          end else begin
            col_d = col_q + POS_W'(1);
          end
        end else if (valid_q && i_ready) begin
          valid_d = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      more_q  <= 1'b0;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      och_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      more_q  <= more_d;
      ch_q    <= ch_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      och_q   <= och_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ch    = och_q;
  assign o_row   = orow_q;
  assign o_col   = ocol_q;
  assign o_last  = last_q;
  assign o_done  = done_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_conv_bin_seq.sv
// tb_conv_bin_seq: randomized self-checking bench for conv_bin_seq.
// Two instances share all inputs: the default BW=8 one and a BW=4 one that
// exercises saturation. Expected beats come from a direct convolution model.
module tb_conv_bin_seq;

  localparam int IMG_W = 28;
  localparam int K     = 5;
  localparam int NCH   = 10;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int NKB   = NCH * K * K;
  localparam int TOTAL = NCH * OUT_W * OUT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [0:NPIX-1]  img_vec;
  logic [0:NKB-1]   ker_vec;
  logic             ready;

  logic             o_valid, o_last, o_busy, o_done;
  logic [7:0]       o_data;
  logic [3:0]       o_ch;
  logic [4:0]       o_row, o_col;

  logic             o_valid4, o_last4, o_busy4, o_done4;
  logic [3:0]       o_data4;
  logic [3:0]       o_ch4;
  logic [4:0]       o_row4, o_col4;

  bit img_m [IMG_W][IMG_W];
  bit ker_m [NCH][K][K];
  bit mode_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_bin_seq #(.IMG_W(IMG_W), .K(K), .NCH(NCH), .BW(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_image(img_vec), .i_kernels(ker_vec), .o_valid(o_valid), .i_ready(ready),
    .o_data(o_data), .o_ch(o_ch), .o_row(o_row), .o_col(o_col),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  conv_bin_seq #(.IMG_W(IMG_W), .K(K), .NCH(NCH), .BW(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_image(img_vec), .i_kernels(ker_vec), .o_valid(o_valid4), .i_ready(ready),
    .o_data(o_data4), .o_ch(o_ch4), .o_row(o_row4), .o_col(o_col4),
    .o_last(o_last4), .o_busy(o_busy4), .o_done(o_done4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Direct convolution: count agreeing (mode 1) or disagreeing (mode 0) pixels.
  function automatic int unsigned ref_cnt(input int ch, input int r, input int c);
    int unsigned n = 0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        if ((img_m[r+kr][c+kc] == ker_m[ch][kr][kc]) == mode_m) n++;
    return n;
  endfunction

  function automatic int unsigned clamp(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic pack_model();
    for (int r = 0; r < IMG_W; r++)
      for (int c = 0; c < IMG_W; c++)
        img_vec[r*IMG_W+c] = img_m[r][c];
    for (int ch = 0; ch < NCH; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          ker_vec[ch*K*K+kr*K+kc] = ker_m[ch][kr][kc];
    mode = mode_m;
  endtask

  task automatic fill(input int img_kind, input int ker_kind, input bit md);
    for (int r = 0; r < IMG_W; r++)
      for (int c = 0; c < IMG_W; c++)
        case (img_kind)
          0: img_m[r][c] = 1'b0;
          1: img_m[r][c] = 1'b1;
          2: img_m[r][c] = (r == 0 && c == 0);
          default: img_m[r][c] = bit'($urandom_range(1));
        endcase
    for (int ch = 0; ch < NCH; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          case (ker_kind)
            0: ker_m[ch][kr][kc] = 1'b0;
            1: ker_m[ch][kr][kc] = (ch == 3);
            default: ker_m[ch][kr][kc] = bit'($urandom_range(1));
          endcase
    mode_m = md;
  endtask

  // Called at a negedge with the DUT idle. abort_at >= 0 resets at that beat.
  task automatic run_frame(input int unsigned ready_pct, input int abort_at, input bit poke);
    int k = 0;
    int cyc = 0;
    int first_valid = -1;
    bit stalled = 1'b0;
    logic [22:0] held = '0;
    logic [22:0] cur;
    logic [22:0] exp;
    bit rd;
    int ch, r, c;
    int unsigned raw;

    pack_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_valid", {o_valid, o_valid4}, 2'b00);
    check_eq("start_busy", {o_busy, o_busy4}, 2'b11);

    while (k < TOTAL && cyc < 20 * TOTAL) begin
      if (poke && k >= 50 && k < 53) begin
        start   = 1'b1;
        img_vec = ~img_vec;
        mode    = ~mode_m;
      end else begin
        start = 1'b0;
        pack_model();
      end
      rd    = ($urandom_range(99) < ready_pct);
      ready = rd;

      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check_eq("abort_valid", {o_valid, o_busy, o_done}, 3'b000);
        ready = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check_eq("abort_idle", {o_valid, o_busy}, 2'b00);
        end
        return;
      end

      cur = {o_ch, o_row, o_col, o_last, o_data};
      if (stalled) check_eq("hold", cur, held);
      if (o_valid && first_valid < 0) first_valid = cyc;

      if (o_valid && rd) begin
        ch  = k / (OUT_W * OUT_W);
        r   = (k / OUT_W) % OUT_W;
        c   = k % OUT_W;
        raw = ref_cnt(ch, r, c);
        exp = {4'(ch), 5'(r), 5'(c), (k == TOTAL - 1), 8'(clamp(raw, 255))};
        check_eq("beat", cur, exp);
        check_eq("beat_bw4", {o_valid4, o_data4}, {1'b1, 4'(clamp(raw, 15))});
        k++;
        stalled = 1'b0;
      end else if (o_valid) begin
        stalled = 1'b1;
        held    = cur;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    pack_model();

    check_eq("beats", 64'(k), 64'(TOTAL));
    check_eq("latency", 64'(first_valid), 64'd1);
    check_eq("done_pulse", {o_done, o_valid, o_busy, o_done4}, 4'b1011);
    @(negedge clk);
    check_eq("done_end", {o_done, o_busy, o_valid}, 3'b000);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    ready   = 1'b0;
    img_vec = '0;
    ker_vec = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_out",
             {o_valid, o_data, o_ch, o_row, o_col, o_last, o_busy, o_done}, '0);
    check_eq("reset_out4", {o_valid4, o_data4, o_busy4, o_done4}, '0);
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    check_eq("idle_out", {o_valid, o_busy, o_done}, 3'b000);

    fill(0, 0, 1'b0); run_frame(100, -1, 1'b0);   // all zero counts
    fill(0, 0, 1'b1); run_frame(100, -1, 1'b0);   // 25, and 15 saturated at BW=4
    fill(1, 1, 1'b0); run_frame(100, -1, 1'b0);   // ch3 zero, others 25
    fill(2, 0, 1'b0); run_frame(100, -1, 1'b0);   // single pixel hit at (0,0)
    fill(3, 3, 1'b0); run_frame(50, -1, 1'b0);    // random, 50% backpressure
    fill(3, 3, 1'b1); run_frame(70, 100, 1'b0);   // reset mid-frame
    fill(3, 3, 1'b1); run_frame(100, -1, 1'b0);   // restart from (0,0,0)
    fill(3, 3, 1'b0); run_frame(100, -1, 1'b1);   // start during RUN ignored
    fill(3, 3, 1'b1); run_frame(80, -1, 1'b0);    // start right after done

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
